// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access codes, the byte-lane mask table and the request fault check.
package ysyx_23060201_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // funct3 access codes
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // Byte-lane mask table; upper nibble is always zero on a 32-bit bus.
    function automatic logic [7:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_B, OP_BU: lane_mask = 8'h01 << off;
            OP_H, OP_HU: lane_mask = 8'h03 << off;
            default:     lane_mask = 8'h0F;
        endcase
    endfunction

    // A request faults when its type is ambiguous, its funct3 is not legal
    // for that type, or its address is not naturally aligned.
    function automatic logic req_fault(input logic       is_load,
                                       input logic       is_store,
                                       input logic [2:0] op,
                                       input logic [1:0] off);
        logic legal;
        logic misaligned;
        legal      = 1'b0;
        misaligned = 1'b0;
        case (op)
            OP_B:    legal = 1'b1;
            OP_H:    begin legal = 1'b1;    misaligned = off[0];          end
            OP_W:    begin legal = 1'b1;    misaligned = (off != 2'b00);  end
            OP_BU:   legal = is_load;
            OP_HU:   begin legal = is_load; misaligned = off[0];          end
            default: legal = 1'b0;
        endcase
        req_fault = (is_load == is_store) || !legal || misaligned;
    endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Load-data extract/extend: shifts the addressed lane of a memory word down
// to bit 0, truncates to the access size and sign- or zero-extends it.
//   word   : full word returned by memory
//   op     : funct3 of the load
//   offset : byte offset within the word (addr[1:0])
//   data   : extended load result
module ysyx_23060201_lsu_align
    import ysyx_23060201_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [2:0]            op,
    input  logic [1:0]            offset,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] lane;

    assign lane = word >> {offset, 3'b000};

    // NOTE: every output of a combinational block gets a value on every path
    // (here via the default arm), otherwise synthesis infers a latch.
    always_comb begin
        case (op)
            OP_B:    data = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
            OP_H:    data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            OP_BU:   data = {{(DATA_WIDTH-8){1'b0}},      lane[7:0]};
            OP_HU:   data = {{(DATA_WIDTH-16){1'b0}},     lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit between EXU and WBU.
//   in_*   : request handshake from EXU (valid/ready, type, funct3, addr, wdata)
//   mem_*  : word-aligned read/write strobes, addresses, lane masks and data
//   out_*  : result handshake to WBU (extended load data, misalign fault)
// Accepted requests wait MEM_LATENCY cycles in ACCESS, then hold their result
// in RESP until WBU takes it. Faulting requests skip ACCESS and issue nothing.
module ysyx_23060201_lsu
    import ysyx_23060201_lsu_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_is_load,
    input  logic                      in_is_store,
    input  logic [2:0]                in_op,
    input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]                mem_rmask,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_rdata,
    output logic                      out_misalign
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

    lsu_state_e                state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [2:0]                op_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      is_load_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      misalign_q;

    logic                      accept;
    logic                      fault;
    logic                      first_access;
    logic                      last_access;
    logic [DATA_WIDTH-1:0]     load_data;

    assign fault        = req_fault(in_is_load, in_is_store, in_op, in_addr[1:0]);
    assign first_access = (state_q == ST_ACCESS) && (cnt_q == LAT_INIT);
    assign last_access  = (state_q == ST_ACCESS) && (cnt_q == 4'd1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (fault) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch and result registers. Result is cleared on accept so
    // stores and faults report zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_load_q  <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= in_op;
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                is_load_q  <= in_is_load;
                rdata_q    <= '0;
                misalign_q <= fault;
            end
            if (last_access && is_load_q) begin
                rdata_q <= load_data;
            end
        end
    end

    ysyx_23060201_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .word   (mem_rdata),
        .op     (op_q),
        .offset (addr_q[1:0]),
        .data   (load_data)
    );

    // Strobes come only from latched state; rst_n gating kills a pending
    // first-cycle write the instant reset is asserted.
    assign mem_ren   = rst_n && (state_q == ST_ACCESS) && is_load_q;
    assign mem_wen   = rst_n && first_access && !is_load_q;
    assign mem_raddr = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign mem_waddr = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign mem_rmask = lane_mask(op_q, addr_q[1:0]);
    assign mem_wmask = lane_mask(op_q, addr_q[1:0]);
    assign mem_wdata = wdata_q << {addr_q[1:0], 3'b000};

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_RESP);
    assign out_rdata    = rdata_q;
    assign out_misalign = misalign_q;

endmodule

// File: doc/ysyx_23060201_lsu.md
YSYX_23060201_LSU -- requirements
Module: ysyx_23060201_LSU

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, ACCESS-state cycles before read data is captured; legal range 1-15.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  request valid from EXU.
REQ-007 SHALL have port in_ready  out  1  LSU accepts request.
REQ-008 SHALL have port in_is_load  in  1  request is a load.
REQ-009 SHALL have port in_is_store  in  1  request is a store.
REQ-010 SHALL have port in_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are loads only.
REQ-011 SHALL have port in_addr  in  MEM_ADDR_WIDTH  byte address.
REQ-012 SHALL have port in_wdata  in  DATA_WIDTH  store data, LSB-justified.
REQ-013 SHALL have port mem_ren  out  1  memory read strobe.
REQ-014 SHALL have port mem_raddr  out  MEM_ADDR_WIDTH  word-aligned read address.
REQ-015 SHALL have port mem_rmask  out  8  read byte-lane mask; bits 7:4 always 0.
REQ-016 SHALL have port mem_rdata  in  DATA_WIDTH  full word returned by memory.
REQ-017 SHALL have port mem_wen  out  1  memory write strobe.
REQ-018 SHALL have port mem_waddr  out  MEM_ADDR_WIDTH  word-aligned write address.
REQ-019 SHALL have port mem_wmask  out  8  write byte-lane mask; bits 7:4 always 0.
REQ-020 SHALL have port mem_wdata  out  DATA_WIDTH  lane-shifted store data.
REQ-021 SHALL have port out_valid  out  1  result valid to WBU.
REQ-022 SHALL have port out_ready  in  1  WBU accepts result.
REQ-023 SHALL have port out_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults.
REQ-024 SHALL have port out_misalign  out  1  fault flag, qualified by out_valid.

Function
REQ-025 SHALL implement FSM IDLE, ACCESS, RESP; in_ready=1 only in IDLE; out_valid=1 only in RESP.
REQ-026 IDLE: on in_valid, latch op/addr/wdata/type; go to ACCESS, or go directly to RESP with out_misalign=1 on fault.
REQ-027 Fault: H/HU with addr[0]=1; W with addr[1:0]!=0; in_op not legal for its type; both or neither of in_is_load/in_is_store set.
REQ-028 Faulting requests SHALL issue no memory strobe.
REQ-029 ACCESS: lasts exactly MEM_LATENCY cycles, tracked by a 4-bit down-counter.
REQ-030 Loads: mem_ren=1 on every ACCESS cycle; mem_rdata captured at the final ACCESS posedge; then go to RESP.
REQ-031 Stores: mem_wen=1 on the first ACCESS cycle only.
REQ-032 Addresses SHALL be in_addr with bits [1:0] cleared; masks: B 0x1<<a, H 0x3<<a, W 0xF, where a=addr[1:0]; mem_wdata=in_wdata<<(8*a).
REQ-033 Load result: captured word >>(8*a), truncated to access size; B/H sign-extended, BU/HU zero-extended.
REQ-034 RESP: outputs held stable until out_valid&out_ready, then return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-035 Latency: request accepted at edge t -> out_valid at cycle t+1+MEM_LATENCY; fault -> out_valid at cycle t+1.
REQ-036 Strobes/addresses SHALL be driven from latched registers only, never combinationally from in_*.

Reset
REQ-037 rst_n=0 at a posedge SHALL force IDLE, counter 0, out_valid/out_misalign/out_rdata 0; while rst_n=0, mem_ren/mem_wen SHALL be 0 combinationally.
REQ-038 Reset during ACCESS SHALL abandon the request with no result; an unissued write SHALL never issue.

Structure
REQ-039 State encodings, funct3 codes, and the mask table SHALL live in shared defines.v.
REQ-040 Extract/extend logic SHALL be one combinational sub-module, ysyx_23060201_LSU_ALIGN.

Verification (mem word 0x80000000=0x8899AABB, MEM_LATENCY=1 unless stated)
REQ-041 LB at 0x80000003 -> raddr 0x80000000, rmask 0x08, out_rdata 0xFFFFFF88 at t+2.
REQ-042 LHU at 0x80000002 -> rmask 0x0C, out_rdata 0x00008899, out_misalign=0.
REQ-043 SB at 0x80000001, wdata 0x123456CD -> single-cycle mem_wen, wmask 0x02, mem_wdata 0x3456CD00.
REQ-044 LW at 0x80000002 -> no strobes, out_valid at t+1, out_misalign=1, out_rdata 0.
REQ-045 out_ready low for 3 cycles in RESP -> out_* stable, in_ready=0, no strobes; accept on cycle 4.
REQ-046 MEM_LATENCY=3, SW, rst_n=0 on ACCESS cycle 1 -> mem_wen stays 0, IDLE at the next cycle, no out_valid.
